// File: rtl/difftest_io_pkg.sv
// Shared constants, exit FSM states and the clamp helper for the difftest IO source.
package difftest_io_pkg;

  localparam logic [63:0] EXIT_GOOD = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    EXIT_RUN    = 2'd0,
    EXIT_DRAIN  = 2'd1,
    EXIT_EXITED = 2'd2
  } exit_state_t;

  // Saturate v at lim; used for the step field and for the backlog counter.
  function automatic logic [31:0] clamp_max(input logic [31:0] v, input logic [31:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/difftest_uart_tx_fifo.sv
// UART-out FIFO: buffers MMIO TX bytes and releases them one per pop,
// with GAP idle cycles enforced after every released byte.
module difftest_uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int GAP   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       out_valid,
  output logic [7:0] out_ch
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [GW-1:0] gap_cnt;
  logic          push, pop;

  // Ready comes from the registered count, so a pop on a full FIFO does not
  // admit a byte in the same cycle.
  assign wr_ready = (count != (AW+1)'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = (count != '0) && (gap_cnt == '0);

  // Storage array; pointer reset alone empties it.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy, pacing counter and the registered output byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      out_ch    <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count + (AW+1)'(push) - (AW+1)'(pop);
      out_valid <= pop;
      if (pop) begin
        out_ch  <= mem[rd_ptr];
        gap_cnt <= GW'(GAP);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/difftest_io_source.sv
// DUT-side producer of the difftest IO bundle: step rate matching, ordered
// exit reporting, UART in/out, log window and perf control edge pulses.
module difftest_io_source
  import difftest_io_pkg::*;
#(
  parameter int STEP_WIDTH = 8,
  parameter int COMMIT_W   = 4,
  parameter int BACKLOG_W  = 16,
  parameter int UART_DEPTH = 16,
  parameter int TX_GAP     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [COMMIT_W-1:0]   commit_cnt,
  input  logic                  trap_valid,
  input  logic                  trap_good,
  input  logic [31:0]           trap_code,
  input  logic                  uart_wr_valid,
  output logic                  uart_wr_ready,
  input  logic [7:0]            uart_wr_data,
  input  logic                  uart_rd_req,
  output logic                  uart_rd_valid,
  output logic [7:0]            uart_rd_data,
  output logic                  log_enable,
  output logic                  perf_clean_pulse,
  output logic                  perf_dump_pulse,
  output logic                  backlog_overflow,
  output logic [STEP_WIDTH-1:0] difftest_step,
  output logic [63:0]           difftest_exit,
  output logic                  difftest_uart_out_valid,
  output logic [7:0]            difftest_uart_out_ch,
  input  logic                  difftest_uart_in_valid,
  input  logic [7:0]            difftest_uart_in_ch,
  input  logic [63:0]           difftest_logCtrl_begin,
  input  logic [63:0]           difftest_logCtrl_end,
  input  logic                  difftest_perfCtrl_clean,
  input  logic                  difftest_perfCtrl_dump
);

  localparam logic [31:0] STEP_MAX    = (32'd1 << STEP_WIDTH) - 32'd1;
  localparam logic [31:0] BACKLOG_MAX = (32'd1 << BACKLOG_W) - 32'd1;

  logic [BACKLOG_W-1:0] backlog;
  logic [31:0]          total, rem;
  exit_state_t          state, state_n;
  logic [63:0]          exit_n;
  logic                 good_q;
  logic [31:0]          code_q;
  logic [63:0]          cycle;
  logic                 clean_r, dump_r;

  // Commits waiting plus commits arriving; whatever exceeds one step stays queued.
  always_comb begin
    total = 32'(backlog) + 32'(commit_cnt);
    rem   = total - clamp_max(total, STEP_MAX);
  end

  // Step release and backlog; overflow saturates and latches until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      difftest_step    <= '0;
      backlog          <= '0;
      backlog_overflow <= 1'b0;
    end else begin
      difftest_step <= STEP_WIDTH'(clamp_max(total, STEP_MAX));
      backlog       <= BACKLOG_W'(clamp_max(rem, BACKLOG_MAX));
      if (rem > BACKLOG_MAX) backlog_overflow <= 1'b1;
    end
  end

  // Exit FSM: the exit code waits until every commit before the trap is stepped out.
  always_comb begin
    state_n = state;
    exit_n  = difftest_exit;
    case (state)
      EXIT_RUN:    if (trap_valid) state_n = EXIT_DRAIN;
      EXIT_DRAIN:  if (backlog == '0) begin
                     state_n = EXIT_EXITED;
                     exit_n  = good_q ? EXIT_GOOD : {32'h0, code_q | 32'd1};
                   end
      EXIT_EXITED: state_n = EXIT_EXITED;
      default:     state_n = EXIT_RUN;
    endcase
  end

  // Exit state, exit code and the trap capture taken only while running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= EXIT_RUN;
      difftest_exit <= '0;
      good_q        <= 1'b0;
      code_q        <= '0;
    end else begin
      state         <= state_n;
      difftest_exit <= exit_n;
      if (state == EXIT_RUN && trap_valid) begin
        good_q <= trap_good;
        code_q <= trap_code;
      end
    end
  end

  // RX read: answer one cycle after the request with the endpoint byte or 0xff.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uart_rd_valid <= 1'b0;
      uart_rd_data  <= 8'h00;
    end else begin
      uart_rd_valid <= uart_rd_req;
      uart_rd_data  <= uart_rd_req ? (difftest_uart_in_valid ? difftest_uart_in_ch : 8'hff) : 8'h00;
    end
  end

  // Free-running cycle counter and the registered log window compare.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle      <= '0;
      log_enable <= 1'b0;
    end else begin
      cycle      <= cycle + 64'd1;
      log_enable <= (difftest_logCtrl_begin != difftest_logCtrl_end) &&
                    (cycle >= difftest_logCtrl_begin) && (cycle < difftest_logCtrl_end);
    end
  end

  // Perf levels are registered once; a pulse marks each rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clean_r          <= 1'b0;
      dump_r           <= 1'b0;
      perf_clean_pulse <= 1'b0;
      perf_dump_pulse  <= 1'b0;
    end else begin
      clean_r          <= difftest_perfCtrl_clean;
      dump_r           <= difftest_perfCtrl_dump;
      perf_clean_pulse <= difftest_perfCtrl_clean && !clean_r;
      perf_dump_pulse  <= difftest_perfCtrl_dump && !dump_r;
    end
  end

  difftest_uart_tx_fifo #(
    .DEPTH (UART_DEPTH),
    .GAP   (TX_GAP)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_valid  (uart_wr_valid),
    .wr_data   (uart_wr_data),
    .wr_ready  (uart_wr_ready),
    .out_valid (difftest_uart_out_valid),
    .out_ch    (difftest_uart_out_ch)
  );

endmodule
